// File: rtl/drw_axi_vram_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : drw_axi_vram_slave_if
// Description : AXI4 bus bundle between the draw engine master port and the
//               VRAM responder. Carries the AW/W/B/AR/R channels; clock and
//               reset stay outside the bundle.
//               master modport : drives AW/W/AR payloads, BREADY, RREADY
//               slave  modport : drives xREADY for AW/W/AR, B and R payloads
// Revision    : 1.0 - initial release
// ============================================================================
interface drw_axi_vram_slave_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // write address channel
    logic [ID_W-1:0]     S_AXI_AWID;
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [7:0]          S_AXI_AWLEN;
    logic [1:0]          S_AXI_AWBURST;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    // write data channel
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WLAST;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    // write response channel
    logic [ID_W-1:0]     S_AXI_BID;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    // read address channel
    logic [ID_W-1:0]     S_AXI_ARID;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [7:0]          S_AXI_ARLEN;
    logic [1:0]          S_AXI_ARBURST;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    // read data channel
    logic [ID_W-1:0]     S_AXI_RID;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RLAST;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface
`default_nettype wire

// File: rtl/drw_axi_vram_slave.sv
`default_nettype none
// ============================================================================
// Module      : drw_axi_vram_slave
// Description : AXI slave responder backed by a word-addressed dual-port RAM.
//               Stands in for DDR VRAM behind the draw engine master port.
//               One write burst and one read burst may be in flight at once
//               (one per direction). Burst-length mismatches between AWLEN
//               and WLAST are reported as SLVERR on BRESP.
// Ports       : ACLK    - clock, rising edge
//               ARESETN - asynchronous active-low reset
//               s_axi   - AXI bus bundle (slave modport):
//                         AW/W/B write path, AR/R read path
// Revision    : 1.0 - initial release
// ============================================================================
module drw_axi_vram_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_AW           = 12
) (
    input  wire logic            ACLK,
    input  wire logic            ARESETN,
    drw_axi_vram_slave_if.slave  s_axi
);

    localparam int         c_strb_w      = C_S_AXI_DATA_WIDTH / 8;
    localparam int         c_depth       = 1 << C_MEM_AW;
    localparam logic [1:0] c_burst_fixed = 2'b00;
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } r_state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [0:c_depth-1];

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    w_state_t                    r_w_state;
    w_state_t                    w_w_state_nxt;
    logic [C_S_AXI_ID_WIDTH-1:0] r_w_id;
    logic [C_MEM_AW-1:0]         r_w_idx;
    logic [7:0]                  r_w_len;
    logic [7:0]                  r_w_cnt;
    logic                        r_w_fixed;
    logic                        r_w_err;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_w_cnt_end;
    logic w_w_final;
    logic w_w_mismatch;

    assign w_aw_hs      = s_axi.S_AXI_AWVALID && (r_w_state == W_IDLE);
    assign w_w_hs       = s_axi.S_AXI_WVALID  && (r_w_state == W_DATA);
    assign w_b_hs       = s_axi.S_AXI_BREADY  && (r_w_state == W_RESP);
    assign w_w_cnt_end  = (r_w_cnt == r_w_len);
    // The burst closes on whichever comes first: the master's WLAST or the
    // beat count implied by AWLEN. Disagreement between the two is an error.
    assign w_w_final    = w_w_hs && (s_axi.S_AXI_WLAST || w_w_cnt_end);
    assign w_w_mismatch = (s_axi.S_AXI_WLAST != w_w_cnt_end);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_w_state <= W_IDLE;
        end else begin
            r_w_state <= w_w_state_nxt;
        end
    end

    always_comb begin
        w_w_state_nxt = r_w_state;
        case (r_w_state)
            W_IDLE:  if (w_aw_hs)   w_w_state_nxt = W_DATA;
            W_DATA:  if (w_w_final) w_w_state_nxt = W_RESP;
            W_RESP:  if (w_b_hs)    w_w_state_nxt = W_IDLE;
            default:                w_w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_w_id    <= '0;
            r_w_idx   <= '0;
            r_w_len   <= '0;
            r_w_cnt   <= '0;
            r_w_fixed <= 1'b0;
            r_w_err   <= 1'b0;
        end else if (w_aw_hs) begin
            r_w_id    <= s_axi.S_AXI_AWID;
            r_w_idx   <= s_axi.S_AXI_AWADDR[C_MEM_AW+1:2];
            r_w_len   <= s_axi.S_AXI_AWLEN;
            r_w_cnt   <= '0;
            r_w_fixed <= (s_axi.S_AXI_AWBURST == c_burst_fixed);
            r_w_err   <= 1'b0;
        end else if (w_w_hs) begin
            r_w_cnt <= r_w_cnt + 8'd1;
            if (!r_w_fixed) begin
                r_w_idx <= r_w_idx + C_MEM_AW'(1);
            end
            if (w_w_mismatch) begin
                r_w_err <= 1'b1;
            end
        end
    end

    // Byte-lane write port; a zero strobe leaves the word untouched.
    always_ff @(posedge ACLK) begin
        if (w_w_hs) begin
            for (int b = 0; b < c_strb_w; b++) begin
                if (s_axi.S_AXI_WSTRB[b]) begin
                    r_mem[r_w_idx][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = (r_w_state == W_IDLE);
    assign s_axi.S_AXI_WREADY  = (r_w_state == W_DATA);
    assign s_axi.S_AXI_BVALID  = (r_w_state == W_RESP);
    // Gate with the state so BRESP reads OKAY outside a response phase.
    assign s_axi.S_AXI_BRESP   = ((r_w_state == W_RESP) && r_w_err) ? c_resp_slverr
                                                                    : c_resp_okay;
    assign s_axi.S_AXI_BID     = r_w_id;

    // ------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------
    r_state_t                      r_r_state;
    r_state_t                      w_r_state_nxt;
    logic [C_S_AXI_ID_WIDTH-1:0]   r_r_id;
    logic [C_MEM_AW-1:0]           r_r_idx;
    logic [7:0]                    r_r_len;
    logic [7:0]                    r_r_cnt;
    logic                          r_r_fixed;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    logic w_ar_hs;
    logic w_r_hs;
    logic w_r_cnt_end;

    assign w_ar_hs     = s_axi.S_AXI_ARVALID && (r_r_state == R_IDLE);
    assign w_r_hs      = s_axi.S_AXI_RREADY  && (r_r_state == R_DATA);
    assign w_r_cnt_end = (r_r_cnt == r_r_len);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_r_state <= R_IDLE;
        end else begin
            r_r_state <= w_r_state_nxt;
        end
    end

    always_comb begin
        w_r_state_nxt = r_r_state;
        case (r_r_state)
            R_IDLE:  if (w_ar_hs) w_r_state_nxt = R_FETCH;
            R_FETCH:              w_r_state_nxt = R_DATA;
            R_DATA: begin
                if (w_r_hs) begin
                    w_r_state_nxt = w_r_cnt_end ? R_IDLE : R_FETCH;
                end
            end
            default:              w_r_state_nxt = R_IDLE;
        endcase
    end

    // RDATA is loaded only in R_FETCH, so it stays put while the master
    // stalls in R_DATA. Reading in the same edge as a write to the same
    // word returns the pre-write contents.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_r_id    <= '0;
            r_r_idx   <= '0;
            r_r_len   <= '0;
            r_r_cnt   <= '0;
            r_r_fixed <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (w_ar_hs) begin
                r_r_id    <= s_axi.S_AXI_ARID;
                r_r_idx   <= s_axi.S_AXI_ARADDR[C_MEM_AW+1:2];
                r_r_len   <= s_axi.S_AXI_ARLEN;
                r_r_cnt   <= '0;
                r_r_fixed <= (s_axi.S_AXI_ARBURST == c_burst_fixed);
            end
            if (r_r_state == R_FETCH) begin
                r_rdata <= r_mem[r_r_idx];
            end
            if (w_r_hs) begin
                r_r_cnt <= r_r_cnt + 8'd1;
                if (!r_r_fixed) begin
                    r_r_idx <= r_r_idx + C_MEM_AW'(1);
                end
            end
        end
    end

    assign s_axi.S_AXI_ARREADY = (r_r_state == R_IDLE);
    assign s_axi.S_AXI_RVALID  = (r_r_state == R_DATA);
    assign s_axi.S_AXI_RLAST   = (r_r_state == R_DATA) && w_r_cnt_end;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RID     = r_r_id;
    assign s_axi.S_AXI_RRESP   = c_resp_okay;

    // Address bits outside the word index are intentionally ignored.
    logic w_unused;
    assign w_unused = &{1'b0,
                        s_axi.S_AXI_AWADDR[1:0],
                        s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:C_MEM_AW+2],
                        s_axi.S_AXI_ARADDR[1:0],
                        s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:C_MEM_AW+2]};

endmodule
`default_nettype wire

// File: tb/tb_drw_axi_vram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_drw_axi_vram_slave
// Description : Directed self-checking bench for drw_axi_vram_slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drw_axi_vram_slave;

    localparam int ID_W   = 1;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MEM_AW = 12;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] FIXED = 2'b00;

    logic ACLK    = 1'b0;
    logic ARESETN = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    logic [31:0] rd_data [0:15];
    logic        rd_last [0:15];

    drw_axi_vram_slave_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    drw_axi_vram_slave #(
        .C_S_AXI_ID_WIDTH   (ID_W),
        .C_S_AXI_ADDR_WIDTH (ADDR_W),
        .C_S_AXI_DATA_WIDTH (DATA_W),
        .C_MEM_AW           (MEM_AW)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .s_axi   (bus.slave)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // ---------------- bus helpers (no comparisons besides timeouts) -------
    task automatic step;
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_aw(input logic [ID_W-1:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
        int k = 0;
        bus.S_AXI_AWID = id; bus.S_AXI_AWADDR = addr;
        bus.S_AXI_AWLEN = len; bus.S_AXI_AWBURST = burst;
        bus.S_AXI_AWVALID = 1'b1;
        while (!bus.S_AXI_AWREADY && k < 50) begin step; k++; end
        if (!bus.S_AXI_AWREADY) begin
            checks++; errors++;
            $display("FAIL aw_timeout: AWREADY got %b required 1", bus.S_AXI_AWREADY);
        end
        step;
        bus.S_AXI_AWVALID = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int k = 0;
        bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb; bus.S_AXI_WLAST = last;
        bus.S_AXI_WVALID = 1'b1;
        while (!bus.S_AXI_WREADY && k < 50) begin step; k++; end
        if (!bus.S_AXI_WREADY) begin
            checks++; errors++;
            $display("FAIL w_timeout: WREADY got %b required 1", bus.S_AXI_WREADY);
        end
        step;
        bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_WLAST  = 1'b0;
    endtask

    task automatic do_b(output logic [1:0] resp, output logic [ID_W-1:0] id);
        int k = 0;
        bus.S_AXI_BREADY = 1'b1;
        while (!bus.S_AXI_BVALID && k < 50) begin step; k++; end
        if (!bus.S_AXI_BVALID) begin
            checks++; errors++;
            $display("FAIL b_timeout: BVALID got %b required 1", bus.S_AXI_BVALID);
        end
        resp = bus.S_AXI_BRESP;
        id   = bus.S_AXI_BID;
        step;
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_ar(input logic [ID_W-1:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
        int k = 0;
        bus.S_AXI_ARID = id; bus.S_AXI_ARADDR = addr;
        bus.S_AXI_ARLEN = len; bus.S_AXI_ARBURST = burst;
        bus.S_AXI_ARVALID = 1'b1;
        while (!bus.S_AXI_ARREADY && k < 50) begin step; k++; end
        if (!bus.S_AXI_ARREADY) begin
            checks++; errors++;
            $display("FAIL ar_timeout: ARREADY got %b required 1", bus.S_AXI_ARREADY);
        end
        step;
        bus.S_AXI_ARVALID = 1'b0;
    endtask

    task automatic wait_rvalid;
        int k = 0;
        while (!bus.S_AXI_RVALID && k < 50) begin step; k++; end
        if (!bus.S_AXI_RVALID) begin
            checks++; errors++;
            $display("FAIL r_timeout: RVALID got %b required 1", bus.S_AXI_RVALID);
        end
    endtask

    task automatic read_beats(input int n);
        bus.S_AXI_RREADY = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_rvalid;
            rd_data[i] = bus.S_AXI_RDATA;
            rd_last[i] = bus.S_AXI_RLAST;
            step;
        end
        bus.S_AXI_RREADY = 1'b0;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                               input logic [31:0] base);
        logic [1:0]      resp;
        logic [ID_W-1:0] id;
        do_aw('0, addr, len, INCR);
        for (int i = 0; i <= int'(len); i++) do_w(base + 32'(i), 4'hF, (i == int'(len)));
        do_b(resp, id);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        ARESETN = 1'b0;
        step; step;
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
             bus.S_AXI_RVALID, bus.S_AXI_RLAST} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_ctrl: {AWRDY,ARRDY,WRDY,BV,RV,RLAST} got %b required 110000",
                     {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY, bus.S_AXI_WREADY,
                      bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_RLAST});
        end
        checks++;
        if ({bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA, bus.S_AXI_BID, bus.S_AXI_RID} !== '0) begin
            errors++;
            $display("FAIL reset_data: BRESP=%b RRESP=%b RDATA=%h BID=%b RID=%b required all 0",
                     bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA, bus.S_AXI_BID, bus.S_AXI_RID);
        end
        ARESETN = 1'b1;
        step;
        // a stray WVALID in W_IDLE must not be accepted
        bus.S_AXI_WVALID = 1'b1; bus.S_AXI_WDATA = 32'hDEAD_BEEF; bus.S_AXI_WSTRB = 4'hF;
        step;
        checks++;
        if (bus.S_AXI_WREADY !== 1'b0 || bus.S_AXI_AWREADY !== 1'b1) begin
            errors++;
            $display("FAIL idle_w_reject: WREADY=%b AWREADY=%b required 0/1",
                     bus.S_AXI_WREADY, bus.S_AXI_AWREADY);
        end
        bus.S_AXI_WVALID = 1'b0;
    endtask

    task automatic test_basic;
        logic [1:0]      resp;
        logic [ID_W-1:0] id;
        do_aw(1'b1, 32'h100, 8'd3, INCR);
        checks++;
        if (bus.S_AXI_AWREADY !== 1'b0 || bus.S_AXI_WREADY !== 1'b1) begin
            errors++;
            $display("FAIL aw_accept: AWREADY=%b WREADY=%b required 0/1",
                     bus.S_AXI_AWREADY, bus.S_AXI_WREADY);
        end
        for (int i = 0; i < 4; i++) do_w(32'hA0 + 32'(i), 4'hF, (i == 3));
        checks++;
        if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_WREADY !== 1'b0) begin
            errors++;
            $display("FAIL basic_bvalid: BVALID=%b WREADY=%b required 1/0",
                     bus.S_AXI_BVALID, bus.S_AXI_WREADY);
        end
        checks++;
        if (bus.S_AXI_BRESP !== 2'b00 || bus.S_AXI_BID !== 1'b1) begin
            errors++;
            $display("FAIL basic_bresp: BRESP=%b BID=%b required 00/1",
                     bus.S_AXI_BRESP, bus.S_AXI_BID);
        end
        do_b(resp, id);
        checks++;
        if (bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_BVALID !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_b: AWREADY=%b BVALID=%b required 1/0",
                     bus.S_AXI_AWREADY, bus.S_AXI_BVALID);
        end
        do_ar(1'b1, 32'h100, 8'd3, INCR);
        checks++;
        if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_ARREADY !== 1'b0) begin
            errors++;
            $display("FAIL read_latency_t1: RVALID=%b ARREADY=%b required 0/0",
                     bus.S_AXI_RVALID, bus.S_AXI_ARREADY);
        end
        step;
        checks++;
        if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RID !== 1'b1) begin
            errors++;
            $display("FAIL read_latency_t2: RVALID=%b RID=%b required 1/1",
                     bus.S_AXI_RVALID, bus.S_AXI_RID);
        end
        read_beats(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== 32'hA0 + 32'(i) || rd_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL basic_read[%0d]: data=%h last=%b required %h/%b",
                         i, rd_data[i], rd_last[i], 32'hA0 + 32'(i), (i == 3));
            end
        end
    endtask

    task automatic test_strobe;
        logic [1:0]      resp;
        logic [ID_W-1:0] id;
        write_burst(32'h0, 8'd0, 32'h1122_3344);
        do_aw('0, 32'h0, 8'd0, INCR);
        do_w(32'hFFFF_FFFF, 4'b0101, 1'b1);
        do_b(resp, id);
        checks++;
        if (resp !== 2'b00) begin
            errors++;
            $display("FAIL strobe_bresp: got %b required 00", resp);
        end
        do_ar('0, 32'h0, 8'd0, INCR);
        read_beats(1);
        checks++;
        if (rd_data[0] !== 32'h11FF_33FF || rd_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL strobe_data: data=%h last=%b required 11ff33ff/1", rd_data[0], rd_last[0]);
        end
    endtask

    task automatic test_mismatch;
        logic [1:0]      resp;
        logic [ID_W-1:0] id;
        logic [31:0]     exp_d [0:3];
        write_burst(32'h200, 8'd3, 32'hB0);
        // early WLAST
        do_aw('0, 32'h200, 8'd3, INCR);
        do_w(32'hC0, 4'hF, 1'b0);
        do_w(32'hC1, 4'hF, 1'b1);
        checks++;
        if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_WREADY !== 1'b0 || bus.S_AXI_BRESP !== 2'b10) begin
            errors++;
            $display("FAIL early_wlast: BVALID=%b WREADY=%b BRESP=%b required 1/0/10",
                     bus.S_AXI_BVALID, bus.S_AXI_WREADY, bus.S_AXI_BRESP);
        end
        do_b(resp, id);
        do_ar('0, 32'h200, 8'd3, INCR);
        read_beats(4);
        exp_d[0] = 32'hC0; exp_d[1] = 32'hC1; exp_d[2] = 32'hB2; exp_d[3] = 32'hB3;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL early_wlast_mem[%0d]: got %h required %h", i, rd_data[i], exp_d[i]);
            end
        end
        // missing WLAST
        do_aw('0, 32'h280, 8'd1, INCR);
        do_w(32'hD0, 4'hF, 1'b0);
        do_w(32'hD1, 4'hF, 1'b0);
        checks++;
        if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_WREADY !== 1'b0 || bus.S_AXI_BRESP !== 2'b10) begin
            errors++;
            $display("FAIL missing_wlast: BVALID=%b WREADY=%b BRESP=%b required 1/0/10",
                     bus.S_AXI_BVALID, bus.S_AXI_WREADY, bus.S_AXI_BRESP);
        end
        do_b(resp, id);
        do_ar('0, 32'h280, 8'd1, INCR);
        read_beats(2);
        checks++;
        if (rd_data[0] !== 32'hD0 || rd_data[1] !== 32'hD1) begin
            errors++;
            $display("FAIL missing_wlast_mem: got %h %h required d0 d1", rd_data[0], rd_data[1]);
        end
    endtask

    task automatic test_backpressure;
        logic [1:0]      resp;
        logic [ID_W-1:0] id;
        logic [31:0]     first;
        do_aw(1'b1, 32'h300, 8'd0, INCR);
        do_w(32'h1234_5678, 4'hF, 1'b1);
        bus.S_AXI_AWVALID = 1'b1;   // a new request must wait for B
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00 ||
                bus.S_AXI_BID !== 1'b1 || bus.S_AXI_AWREADY !== 1'b0) begin
                errors++;
                $display("FAIL b_stall[%0d]: BVALID=%b BRESP=%b BID=%b AWREADY=%b required 1/00/1/0",
                         c, bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_BID, bus.S_AXI_AWREADY);
            end
            step;
        end
        bus.S_AXI_AWVALID = 1'b0;
        do_b(resp, id);
        // read stall after the first beat
        do_ar('0, 32'h100, 8'd3, INCR);
        read_beats(1);
        first = rd_data[0];
        wait_rvalid;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'hA1 || bus.S_AXI_RLAST !== 1'b0) begin
                errors++;
                $display("FAIL r_stall[%0d]: RVALID=%b RDATA=%h RLAST=%b required 1/a1/0",
                         c, bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_RLAST);
            end
            step;
        end
        read_beats(3);
        checks++;
        if (first !== 32'hA0 || rd_data[0] !== 32'hA1 || rd_data[1] !== 32'hA2 ||
            rd_data[2] !== 32'hA3 || rd_last[1] !== 1'b0 || rd_last[2] !== 1'b1) begin
            errors++;
            $display("FAIL r_stall_seq: got %h %h %h %h last=%b%b required a0 a1 a2 a3 last=01",
                     first, rd_data[0], rd_data[1], rd_data[2], rd_last[1], rd_last[2]);
        end
    endtask

    task automatic test_wrap_fixed;
        logic [1:0]      resp;
        logic [ID_W-1:0] id;
        do_aw('0, 32'h3FFC, 8'd1, INCR);
        do_w(32'hE0, 4'hF, 1'b0);
        do_w(32'hE1, 4'hF, 1'b1);
        do_b(resp, id);
        checks++;
        if (resp !== 2'b00) begin
            errors++;
            $display("FAIL wrap_bresp: got %b required 00", resp);
        end
        do_ar('0, 32'h3FFC, 8'd1, INCR);
        read_beats(2);
        checks++;
        if (rd_data[0] !== 32'hE0 || rd_data[1] !== 32'hE1) begin
            errors++;
            $display("FAIL wrap_read: got %h %h required e0 e1", rd_data[0], rd_data[1]);
        end
        // upper address bits alias onto word 0
        do_ar('0, 32'h4000, 8'd0, INCR);
        read_beats(1);
        checks++;
        if (rd_data[0] !== 32'hE1) begin
            errors++;
            $display("FAIL wrap_index0: got %h required e1", rd_data[0]);
        end
        do_ar('0, 32'h100, 8'd2, FIXED);
        read_beats(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_data[i] !== 32'hA0 || rd_last[i] !== (i == 2)) begin
                errors++;
                $display("FAIL fixed_read[%0d]: data=%h last=%b required a0/%b",
                         i, rd_data[i], rd_last[i], (i == 2));
            end
        end
    endtask

    task automatic test_concurrent;
        logic [1:0]      resp_c;
        logic [ID_W-1:0] id_c;
        int              bad;
        write_burst(32'h400, 8'd15, 32'h0F00);
        fork
            begin
                do_aw('0, 32'h800, 8'd15, INCR);
                for (int i = 0; i < 16; i++) do_w(32'h5000 + 32'(i), 4'hF, (i == 15));
                do_b(resp_c, id_c);
            end
            begin
                do_ar('0, 32'h400, 8'd15, INCR);
                read_beats(16);
            end
        join
        checks++;
        if (resp_c !== 2'b00) begin
            errors++;
            $display("FAIL conc_bresp: got %b required 00", resp_c);
        end
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (rd_data[i] !== 32'h0F00 + 32'(i) || rd_last[i] !== (i == 15)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL conc_read: %0d beats wrong, first=%h last15=%b required 00000f00.., last15=1",
                     bad, rd_data[0], rd_last[15]);
        end
        do_ar('0, 32'h800, 8'd15, INCR);
        read_beats(16);
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (rd_data[i] !== 32'h5000 + 32'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL conc_write: %0d words wrong, word0=%h word15=%h required 5000/500f",
                     bad, rd_data[0], rd_data[15]);
        end
    endtask

    task automatic test_reset_mid;
        do_ar('0, 32'h400, 8'd15, INCR);
        read_beats(2);
        wait_rvalid;
        #2 ARESETN = 1'b0;
        #1;
        checks++;
        if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_RLAST !== 1'b0 || bus.S_AXI_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_read: RVALID=%b RLAST=%b RDATA=%h required 0/0/0",
                     bus.S_AXI_RVALID, bus.S_AXI_RLAST, bus.S_AXI_RDATA);
        end
        step; step;
        ARESETN = 1'b1;
        step;
        checks++;
        if (bus.S_AXI_ARREADY !== 1'b1 || bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_RVALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ARREADY=%b AWREADY=%b RVALID=%b required 1/1/0",
                     bus.S_AXI_ARREADY, bus.S_AXI_AWREADY, bus.S_AXI_RVALID);
        end
        do_ar('0, 32'h404, 8'd0, INCR);
        read_beats(1);
        checks++;
        if (rd_data[0] !== 32'h0F01 || rd_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL ram_kept: data=%h last=%b required 00000f01/1", rd_data[0], rd_last[0]);
        end
    endtask

    initial begin
        bus.S_AXI_AWID = '0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0;
        bus.S_AXI_AWBURST = INCR; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0;
        bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARID = '0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0;
        bus.S_AXI_ARBURST = INCR; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;

        test_reset;
        test_basic;
        test_strobe;
        test_mismatch;
        test_backpressure;
        test_wrap_fixed;
        test_concurrent;
        test_reset_mid;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/drw_axi_vram_slave.md
Name: drw_axi_vram_slave

Overview:
- AXI slave responder with an internal word-addressed RAM; the target end of the draw engine's AXI master port.
- Serves independent read and write bursts with one transaction outstanding per direction.
- Stands in for DDR VRAM in block-level simulation and in FPGA loopback builds.
- Reports burst-length mismatches through BRESP so master-side burst-generation bugs surface.

Parameters:
- C_S_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID.
- C_S_AXI_ADDR_WIDTH, 32, byte address width.
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_MEM_AW, 12, log2 of RAM depth in 32-bit words; depth = 2^C_MEM_AW.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWID  in  ID_W  write ID; latched at AW handshake.
- S_AXI_AWADDR  in  ADDR_W  write start byte address.
- S_AXI_AWLEN  in  8  beats minus 1.
- S_AXI_AWBURST  in  2  01=INCR, 00=FIXED; other codes are treated as INCR.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  AW handshake pair.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WLAST  in  1  final beat marker from the master.
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  W handshake pair.
- S_AXI_BID  out  ID_W  echoes the latched AWID.
- S_AXI_BRESP  out  2  00=OKAY, 10=SLVERR.
- S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  B handshake pair.
- S_AXI_ARID  in  ID_W  read ID; latched at AR handshake.
- S_AXI_ARADDR  in  ADDR_W  read start byte address.
- S_AXI_ARLEN  in  8  beats minus 1.
- S_AXI_ARBURST  in  2  burst type; same rules as AWBURST.
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  AR handshake pair.
- S_AXI_RID  out  ID_W  echoes the latched ARID.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 00.
- S_AXI_RLAST  out  1  high on the final read beat.
- S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  R handshake pair.

Behaviour:
- Reset (ARESETN low, asynchronous):
  - Both FSMs return to IDLE.
  - AWREADY=1, ARREADY=1.
  - WREADY, BVALID, RVALID and RLAST are 0.
  - BRESP, RRESP, RDATA, BID and RID are 0.
  - RAM contents are not reset.
  - Reset mid-burst abandons the burst without issuing a response.
- Address mapping:
  - Word index = addr[C_MEM_AW+1:2]; upper bits and addr[1:0] are ignored.
  - The index increments by 1 per beat for INCR (wraps modulo depth) and is held for FIXED.
  - AWSIZE/ARSIZE are not ports; 4 bytes/beat is implied.
- Write FSM: W_IDLE -> W_DATA -> W_RESP.
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY at cycle T: latch ID, index, len and burst; beat counter=0; go to W_DATA. AWREADY=0 from T+1.
  - W_DATA: WREADY=1 from T+1. Each WVALID&WREADY writes the bytes with WSTRB[i]=1 (WSTRB=0 writes nothing) and increments the beat counter.
  - Mismatch: set a sticky error flag if WLAST=1 while beat counter != len, or WLAST=0 while beat counter == len.
  - The burst ends on a WLAST beat or on beat len+1, whichever comes first. On the final beat at cycle U, WREADY=0 and BVALID=1 at U+1.
  - W_RESP: BRESP=10 if the error flag is set, else 00. Hold BVALID/BRESP/BID until BREADY. The cycle after the B handshake: W_IDLE, AWREADY=1.
  - WVALID seen in W_IDLE or W_RESP is not accepted (WREADY=0).
- Read FSM: R_IDLE -> R_FETCH -> R_DATA.
  - R_IDLE: ARREADY=1. On AR handshake at cycle T: latch ID, index, len and burst; go to R_FETCH. ARREADY=0 from T+1.
  - R_FETCH: lasts one cycle and issues a synchronous RAM read.
  - R_DATA: RVALID=1 at T+2 with RDATA; RLAST=1 when beat counter == len. RDATA/RLAST/RID are held stable while RVALID&!RREADY.
  - R handshake on a non-last beat at U: RVALID=0 at U+1 (R_FETCH); next beat valid at U+2.
  - R handshake on the last beat: R_IDLE; ARREADY=1 next cycle.
  - Throughput is therefore 1 beat per 2 cycles.
- Concurrency:
  - Read and write FSMs run fully independently and may be active simultaneously. The RAM is dual-port.
  - A read and a write to the same word in the same cycle return the old data (read-first).
- Data width: RAM is 2^C_MEM_AW x 32 with per-byte write enables. No combinational path from any input to any output.

Test Plan:
- Reset, then AW(addr=0x100, len=3, ID=1) and 4 W beats 0xA0..0xA3 with WSTRB=F, WLAST on beat 4 -> BVALID 1 cycle after the last beat; BRESP=00, BID=1. Then AR(addr=0x100, len=3) -> RDATA A0,A1,A2,A3; first RVALID 2 cycles after AR; RLAST only on beat 4.
- Write 0x11223344 to 0x0, then a single beat 0xFFFFFFFF with WSTRB=0101 -> readback 0x11FF33FF.
- AWLEN=3 with WLAST on beat 2 -> burst ends after 2 beats; BRESP=10; words 2-3 unchanged. AWLEN=1 with WLAST never asserted -> ends after beat 2; BRESP=10.
- Hold BREADY=0 for 5 cycles -> BVALID/BRESP stable and AWREADY=0 throughout. Hold RREADY=0 mid-burst -> RDATA/RLAST stable, no beat skipped.
- INCR write at word index 2^C_MEM_AW-1, len=1 -> second beat lands at index 0. FIXED read len=2 -> the same word returned 3 times.
- Concurrent 16-beat write and 16-beat read to disjoint regions -> both complete with correct data. Assert ARESETN low mid-read -> RVALID=0 immediately; ARREADY=1 and AWREADY=1 after release.
